// File: rtl/indian_poker_ctrl.sv
// Two-player Indian Poker round controller: antes, bet/call/fold turns, showdown payout, game-over.
// Optional fold-with-top-card penalty compiled in with IPK_FOLD_PENALTY_EN.
module indian_poker_ctrl #(
   parameter int CHIP_W     = 4,
   parameter int INIT_CHIPS = 8,
   parameter int CARD_W     = 4,
   parameter int MAX_RAISE  = 3
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              deal,
   input  logic [CARD_W-1:0] card_a,
   input  logic [CARD_W-1:0] card_b,
   input  logic              bet,
   input  logic              call,
   input  logic              fold,
   output logic [CHIP_W-1:0] chips_a,
   output logic [CHIP_W-1:0] chips_b,
   output logic [CHIP_W:0]   pot,
   output logic              turn,
   output logic [1:0]        state,
   output logic              win_a,
   output logic              win_b,
   output logic              game_over
);
   localparam int PW = CHIP_W + 1;
   localparam int AW = CHIP_W + 2;
   localparam int RW = (MAX_RAISE < 1) ? 1 : $clog2(MAX_RAISE + 1);
   localparam logic [CHIP_W-1:0] MAXC = '1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BET = 2'd1, S_SHOW = 2'd2, S_OVER = 2'd3} state_t;

   state_t            r_state, w_state_nxt;
   logic [CHIP_W-1:0] r_chips_a, r_chips_b, w_chips_a_nxt, w_chips_b_nxt;
   logic [PW-1:0]     r_pot, w_pot_nxt;
   logic [PW-1:0]     r_contrib_a, r_contrib_b, w_contrib_a_nxt, w_contrib_b_nxt;
   logic              r_turn, w_turn_nxt, r_first, w_first_nxt;
   logic [RW-1:0]     r_raise_cnt, w_raise_cnt_nxt;
   logic [CARD_W-1:0] r_card_a, r_card_b, w_card_a_nxt, w_card_b_nxt;
   logic [1:0]        r_win_sel, w_win_sel_nxt;   // {A wins, B wins}; both set on a tie
   logic              r_win_a, r_win_b, w_win_a_nxt, w_win_b_nxt;
   logic              r_game_over, w_game_over_nxt;
`ifdef IPK_FOLD_PENALTY_EN
   logic              r_pen, w_pen_nxt;
   logic [CHIP_W-1:0] w_pen_src;
`endif

   logic [PW-1:0]     w_owed, w_chips_p, w_call_amt, w_bet_amt;
   logic              w_bet_ok;
   logic [CHIP_W-1:0] w_pen, w_half, w_sub_a, w_sub_b, w_pay_a, w_pay_b;
   logic              w_odd;
   logic [AW-1:0]     w_add_a, w_add_b, w_sum_a, w_sum_b;

   assign w_owed     = r_turn ? (r_contrib_a - r_contrib_b) : (r_contrib_b - r_contrib_a);
   assign w_chips_p  = r_turn ? {1'b0, r_chips_b} : {1'b0, r_chips_a};
   assign w_call_amt = (w_owed < w_chips_p) ? w_owed : w_chips_p;
   assign w_bet_amt  = w_owed + PW'(1);
   assign w_bet_ok   = (w_chips_p >= w_bet_amt) && (r_raise_cnt < RW'(MAX_RAISE));
   assign w_half     = r_pot[CHIP_W:1];
   assign w_odd      = r_pot[0];

`ifdef IPK_FOLD_PENALTY_EN
   // The folder is always the non-winner, so the penalty comes out of the loser's stack.
   assign w_pen_src = r_win_sel[1] ? r_chips_b : r_chips_a;
   assign w_pen     = !r_pen ? '0 : ((w_pen_src > CHIP_W'(2)) ? CHIP_W'(2) : w_pen_src);
`else
   assign w_pen = '0;
`endif

   always_comb begin
      w_add_a = '0;
      w_add_b = '0;
      w_sub_a = '0;
      w_sub_b = '0;
      case (r_win_sel)
         2'b10: begin
            w_add_a = AW'(r_pot) + AW'(w_pen);
            w_sub_b = w_pen;
         end
         2'b01: begin
            w_add_b = AW'(r_pot) + AW'(w_pen);
            w_sub_a = w_pen;
         end
         default: begin
            w_add_a = AW'(w_half) + AW'(w_odd & ~r_first);
            w_add_b = AW'(w_half) + AW'(w_odd & r_first);
         end
      endcase
      w_sum_a = AW'(r_chips_a - w_sub_a) + w_add_a;
      w_sum_b = AW'(r_chips_b - w_sub_b) + w_add_b;
      w_pay_a = (w_sum_a > AW'(MAXC)) ? MAXC : w_sum_a[CHIP_W-1:0];
      w_pay_b = (w_sum_b > AW'(MAXC)) ? MAXC : w_sum_b[CHIP_W-1:0];
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_chips_a_nxt   = r_chips_a;
      w_chips_b_nxt   = r_chips_b;
      w_pot_nxt       = r_pot;
      w_contrib_a_nxt = r_contrib_a;
      w_contrib_b_nxt = r_contrib_b;
      w_turn_nxt      = r_turn;
      w_first_nxt     = r_first;
      w_raise_cnt_nxt = r_raise_cnt;
      w_card_a_nxt    = r_card_a;
      w_card_b_nxt    = r_card_b;
      w_win_sel_nxt   = r_win_sel;
      w_win_a_nxt     = 1'b0;
      w_win_b_nxt     = 1'b0;
      w_game_over_nxt = r_game_over;
`ifdef IPK_FOLD_PENALTY_EN
      w_pen_nxt       = r_pen;
`endif
      case (r_state)
         S_IDLE: begin
            if (deal) begin
               w_card_a_nxt    = card_a;
               w_card_b_nxt    = card_b;
               w_chips_a_nxt   = r_chips_a - CHIP_W'(1);
               w_chips_b_nxt   = r_chips_b - CHIP_W'(1);
               w_pot_nxt       = PW'(2);
               w_contrib_a_nxt = PW'(1);
               w_contrib_b_nxt = PW'(1);
               w_raise_cnt_nxt = '0;
               w_turn_nxt      = r_first;
               w_state_nxt     = S_BET;
            end
         end
         S_BET: begin
            if (fold) begin
               w_win_sel_nxt = r_turn ? 2'b10 : 2'b01;
               w_state_nxt   = S_SHOW;
`ifdef IPK_FOLD_PENALTY_EN
               w_pen_nxt     = r_turn ? (&r_card_b) : (&r_card_a);
`endif
            end else if (call) begin
               if (r_turn) begin
                  w_chips_b_nxt   = r_chips_b - w_call_amt[CHIP_W-1:0];
                  w_contrib_b_nxt = r_contrib_b + w_call_amt;
               end else begin
                  w_chips_a_nxt   = r_chips_a - w_call_amt[CHIP_W-1:0];
                  w_contrib_a_nxt = r_contrib_a + w_call_amt;
               end
               w_pot_nxt     = r_pot + w_call_amt;
               w_win_sel_nxt = (r_card_a > r_card_b) ? 2'b10 :
                               (r_card_a < r_card_b) ? 2'b01 : 2'b11;
               w_state_nxt   = S_SHOW;
            end else if (bet && w_bet_ok) begin
               if (r_turn) begin
                  w_chips_b_nxt   = r_chips_b - w_bet_amt[CHIP_W-1:0];
                  w_contrib_b_nxt = r_contrib_b + w_bet_amt;
               end else begin
                  w_chips_a_nxt   = r_chips_a - w_bet_amt[CHIP_W-1:0];
                  w_contrib_a_nxt = r_contrib_a + w_bet_amt;
               end
               w_pot_nxt       = r_pot + w_bet_amt;
               w_raise_cnt_nxt = r_raise_cnt + RW'(1);
               w_turn_nxt      = ~r_turn;
            end
         end
         S_SHOW: begin
            w_chips_a_nxt   = w_pay_a;
            w_chips_b_nxt   = w_pay_b;
            w_pot_nxt       = '0;
            w_contrib_a_nxt = '0;
            w_contrib_b_nxt = '0;
            w_first_nxt     = ~r_first;
            w_win_a_nxt     = r_win_sel[1];
            w_win_b_nxt     = r_win_sel[0];
`ifdef IPK_FOLD_PENALTY_EN
            w_pen_nxt       = 1'b0;
`endif
            if ((w_pay_a == '0) || (w_pay_b == '0)) begin
               w_game_over_nxt = 1'b1;
               w_state_nxt     = S_OVER;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state     <= S_IDLE;
         r_chips_a   <= CHIP_W'(INIT_CHIPS);
         r_chips_b   <= CHIP_W'(INIT_CHIPS);
         r_pot       <= '0;
         r_contrib_a <= '0;
         r_contrib_b <= '0;
         r_turn      <= 1'b0;
         r_first     <= 1'b0;
         r_raise_cnt <= '0;
         r_card_a    <= '0;
         r_card_b    <= '0;
         r_win_sel   <= '0;
         r_win_a     <= 1'b0;
         r_win_b     <= 1'b0;
         r_game_over <= 1'b0;
`ifdef IPK_FOLD_PENALTY_EN
         r_pen       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_chips_a   <= w_chips_a_nxt;
         r_chips_b   <= w_chips_b_nxt;
         r_pot       <= w_pot_nxt;
         r_contrib_a <= w_contrib_a_nxt;
         r_contrib_b <= w_contrib_b_nxt;
         r_turn      <= w_turn_nxt;
         r_first     <= w_first_nxt;
         r_raise_cnt <= w_raise_cnt_nxt;
         r_card_a    <= w_card_a_nxt;
         r_card_b    <= w_card_b_nxt;
         r_win_sel   <= w_win_sel_nxt;
         r_win_a     <= w_win_a_nxt;
         r_win_b     <= w_win_b_nxt;
         r_game_over <= w_game_over_nxt;
`ifdef IPK_FOLD_PENALTY_EN
         r_pen       <= w_pen_nxt;
`endif
      end
   end

   assign chips_a   = r_chips_a;
   assign chips_b   = r_chips_b;
   assign pot       = r_pot;
   assign turn      = r_turn;
   assign state     = r_state;
   assign win_a     = r_win_a;
   assign win_b     = r_win_b;
   assign game_over = r_game_over;
endmodule

// File: tb/tb_indian_poker_ctrl.sv
// Bench for indian_poker_ctrl: player-indexed game model checked every cycle plus hand-computed expectations.
module tb_indian_poker_ctrl;
   localparam int INIT = 8;
   localparam int MAXC = 15;
   localparam int MAXR = 3;

   logic       CLK, CLR, deal, bet, call, fold;
   logic [3:0] card_a, card_b, chips_a, chips_b;
   logic [4:0] pot;
   logic       turn, win_a, win_b, game_over;
   logic [1:0] state;

   indian_poker_ctrl dut (
      .CLK(CLK), .CLR(CLR), .deal(deal), .card_a(card_a), .card_b(card_b),
      .bet(bet), .call(call), .fold(fold), .chips_a(chips_a), .chips_b(chips_b),
      .pot(pot), .turn(turn), .state(state), .win_a(win_a), .win_b(win_b),
      .game_over(game_over)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // Game model: index 0 = player A, 1 = player B.  State 0 idle, 1 betting, 2 showdown, 3 over.
   int m_chips[2], m_contrib[2], m_card[2], m_win[2];
   int m_pot, m_turn, m_first, m_raises, m_state, m_over, m_winner, m_pen_folder;

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_chips[i] = INIT; m_contrib[i] = 0; m_card[i] = 0; m_win[i] = 0;
      end
      m_pot = 0; m_turn = 0; m_first = 0; m_raises = 0;
      m_state = 0; m_over = 0; m_winner = 0; m_pen_folder = -1;
   endfunction

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_edge(input bit d, input bit b, input bit c, input bit f,
                                      input int ca, input int cb);
      int p, o, owed, amt, half, l, w, pen;
      m_win[0] = 0; m_win[1] = 0;
      if (m_state == 0) begin
         if (d) begin
            m_card[0] = ca; m_card[1] = cb;
            for (int i = 0; i < 2; i++) begin
               m_chips[i]--; m_contrib[i] = 1;
            end
            m_pot = 2; m_raises = 0; m_turn = m_first; m_state = 1;
         end
      end else if (m_state == 1) begin
         p = m_turn; o = 1 - p;
         owed = m_contrib[o] - m_contrib[p];
         if (f) begin
            m_winner = o;
            m_pen_folder = (m_card[p] == 15) ? p : -1;
            m_state = 2;
         end else if (c) begin
            amt = min2(owed, m_chips[p]);
            m_chips[p] -= amt; m_contrib[p] += amt; m_pot += amt;
            m_winner = (m_card[0] > m_card[1]) ? 0 : (m_card[0] < m_card[1]) ? 1 : 2;
            m_pen_folder = -1;
            m_state = 2;
         end else if (b && m_chips[p] >= owed + 1 && m_raises < MAXR) begin
            m_chips[p] -= owed + 1; m_contrib[p] += owed + 1; m_pot += owed + 1;
            m_raises++; m_turn = o;
         end
      end else if (m_state == 2) begin
         if (m_winner == 2) begin
            half = m_pot / 2;
            m_chips[0] = sat(m_chips[0] + half + (((m_pot % 2) == 1 && m_first == 0) ? 1 : 0));
            m_chips[1] = sat(m_chips[1] + half + (((m_pot % 2) == 1 && m_first == 1) ? 1 : 0));
            m_win[0] = 1; m_win[1] = 1;
         end else begin
            w = m_winner; l = 1 - w; pen = 0;
`ifdef IPK_FOLD_PENALTY_EN
            if (m_pen_folder == l) pen = min2(2, m_chips[l]);
`endif
            m_chips[l] -= pen;
            m_chips[w] = sat(m_chips[w] + m_pot + pen);
            m_win[w] = 1;
         end
         m_pot = 0; m_contrib[0] = 0; m_contrib[1] = 0;
         m_first = 1 - m_first; m_pen_folder = -1;
         if (m_chips[0] == 0 || m_chips[1] == 0) begin
            m_state = 3; m_over = 1;
         end else begin
            m_state = 0;
         end
      end
   endfunction

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("cyc_chips_a", chips_a, m_chips[0]);
         chk("cyc_chips_b", chips_b, m_chips[1]);
         chk("cyc_pot", pot, m_pot);
         chk("cyc_turn", turn, m_turn);
         chk("cyc_state", state, m_state);
         chk("cyc_win_a", win_a, m_win[0]);
         chk("cyc_win_b", win_b, m_win[1]);
         chk("cyc_game_over", game_over, m_over);
      end
   end

   // Called just after a rising edge; drives one cycle of pulses and advances the model.
   task automatic cyc(input bit d, input bit b, input bit c, input bit f, input int ca, input int cb);
      deal = d; bet = b; call = c; fold = f;
      card_a = 4'(ca); card_b = 4'(cb);
      @(posedge CLK); #1;
      model_edge(d, b, c, f, ca, cb);
      deal = 1'b0; bet = 1'b0; call = 1'b0; fold = 1'b0;
   endtask

   task automatic mid_reset();
      CLR = 1'b0;
      model_reset();
      #2;
      chk("rst_chips_a", chips_a, INIT);
      chk("rst_chips_b", chips_b, INIT);
      chk("rst_pot", pot, 0);
      chk("rst_state", state, 0);
      chk("rst_game_over", game_over, 0);
      @(negedge CLK); #1 CLR = 1'b1;
      @(posedge CLK); #1;
      model_edge(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      deal = 0; bet = 0; call = 0; fold = 0; card_a = 0; card_b = 0;
      CLR = 1'b1;
      #1 CLR = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("init_chips_a", chips_a, 8);
      chk("init_chips_b", chips_b, 8);
      chk("init_pot", pot, 0);
      chk("init_state", state, 0);
      chk("init_turn", turn, 0);
      chk("init_win", {win_a, win_b}, 0);
      CLR = 1'b1;
      cmp_en = 1'b1;

      // A 9 vs B 3, A checks
      cyc(1, 0, 0, 0, 9, 3);
      chk("r1_pot_ante", pot, 2);
      chk("r1_state_bet", state, 1);
      cyc(0, 0, 1, 0, 0, 0);
      chk("r1_state_show", state, 2);
      cyc(0, 0, 0, 0, 0, 0);
      chk("r1_chips_a", chips_a, 9);
      chk("r1_chips_b", chips_b, 7);
      chk("r1_win_a", win_a, 1);
      chk("r1_pot_zero", pot, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("r1_win_a_drop", win_a, 0);
      cyc(1, 0, 0, 0, 6, 6);
      chk("r2_turn_b", turn, 1);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      chk("r2_pot_show", pot, 4);
      mid_reset();

      // A bet, B bet, A call; B's 7 beats A's 2
      cyc(1, 0, 0, 0, 2, 7);
      chk("bb_pot0", pot, 2);
      cyc(0, 1, 0, 0, 0, 0);
      chk("bb_pot1", pot, 3);
      cyc(0, 1, 0, 0, 0, 0);
      chk("bb_pot2", pot, 5);
      cyc(0, 0, 1, 0, 0, 0);
      chk("bb_pot3", pot, 6);
      cyc(0, 0, 0, 0, 0, 0);
      chk("bb_chips_a", chips_a, 5);
      chk("bb_chips_b", chips_b, 11);
      chk("bb_win_b", win_b, 1);
      mid_reset();

      // raise cap: fourth bet ignored
      cyc(1, 0, 0, 0, 4, 4);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
      chk("cap_turn", turn, 1);
      chk("cap_pot", pot, 7);
      chk("cap_chips_a", chips_a, 4);
      cyc(0, 1, 1, 0, 0, 0);
      chk("cap_call_wins", state, 2);
      cyc(0, 0, 0, 0, 0, 0);
      chk("cap_tie_a", chips_a, 8);
      mid_reset();

      // A folds holding the top card
      cyc(1, 0, 0, 0, 15, 3);
      cyc(0, 1, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
`ifdef IPK_FOLD_PENALTY_EN
      chk("fold_chips_a", chips_a, 5);
      chk("fold_chips_b", chips_b, 11);
`else
      chk("fold_chips_a", chips_a, 7);
      chk("fold_chips_b", chips_b, 9);
`endif
      mid_reset();

      // multi-round game to exhaustion
      cyc(1, 0, 0, 0, 10, 2);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("g1_chips_a", chips_a, 12);
      chk("g1_chips_b", chips_b, 4);
      cyc(1, 0, 0, 0, 10, 2);
      chk("g2_turn", turn, 1);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("g2_chips_a", chips_a, 15);
      chk("g2_chips_b", chips_b, 1);
      cyc(1, 0, 0, 0, 5, 5);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("g3_poor_bet_turn", turn, 1);
      chk("g3_poor_bet_pot", pot, 3);
      cyc(0, 0, 1, 0, 0, 0);
      chk("g3_short_call_pot", pot, 3);
      cyc(0, 0, 0, 0, 0, 0);
      chk("g3_tie_wins", {win_a, win_b}, 3);
      chk("g3_chips_a", chips_a, 15);
      chk("g3_chips_b", chips_b, 1);
      cyc(1, 0, 0, 0, 1, 2);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("g4_state_over", state, 3);
      chk("g4_game_over", game_over, 1);
      chk("g4_chips_a_sat", chips_a, 15);
      chk("g4_chips_b", chips_b, 0);
      cyc(1, 0, 0, 0, 3, 4);
      cyc(0, 1, 1, 0, 0, 0);
      chk("over_deal_ignored", state, 3);
      chk("over_pot", pot, 0);
      cyc(0, 0, 0, 0, 0, 0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
